// File: rtl/apb_req_sequencer.sv
// Request sequencer in front of an APB master: buffers valid/ready commands in a
// small FIFO, replays them one at a time on the master's request pins, returns read responses.
module apb_req_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int AW      = 8,
    parameter int DW      = 8
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          transfer,
    output logic          pwrite_out,
    output logic [AW-1:0] paddr_out,
    output logic [DW-1:0] pwdata_out,
    input  logic          xfer_done,
    input  logic [DW-1:0] read_data_in,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          err_sticky,
    input  logic          err_clr,
    output logic          busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = 1 + AW + DW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          transfer_q, transfer_d;
    logic          pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          err_sticky_q, err_sticky_d;

    logic          full, empty, push, pop;
    logic [EW-1:0] head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = cmd_valid && !full;
    assign pop   = (state_q == IDLE) && !empty;
    assign head  = mem_q[rptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        transfer_d   = transfer_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        err_sticky_d = err_sticky_q && !err_clr;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    {pwrite_d, paddr_d, pwdata_d} = head;
                    transfer_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                cnt_d = cnt_q + TW'(1);
                if (xfer_done) begin
                    transfer_d = 1'b0;
                    if (pwrite_q) begin
                        state_d = IDLE;
                    end else begin
                        rsp_rdata_d = read_data_in;
                        rsp_err_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    // a timeout set overrides a simultaneous err_clr
                    transfer_d   = 1'b0;
                    err_sticky_d = 1'b1;
                    if (pwrite_q) begin
                        state_d = IDLE;
                    end else begin
                        rsp_rdata_d = '1;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            cnt_q        <= '0;
            transfer_q   <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            cnt_q        <= cnt_d;
            transfer_q   <= transfer_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign cmd_ready  = !full;
    assign transfer   = transfer_q;
    assign pwrite_out = pwrite_q;
    assign paddr_out  = paddr_q;
    assign pwdata_out = pwdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign err_sticky = err_sticky_q;
    assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_apb_req_sequencer.sv
// Bench for apb_req_sequencer: transaction-level model (command queue plus in-flight
// and pending-response records) compared against the DUT every cycle, plus directed pins.
module tb_apb_req_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
    } cmd_t;

    logic       pclk = 1'b0;
    logic       preset, cmd_valid, cmd_write, xfer_done, rsp_ready, err_clr;
    logic [7:0] cmd_addr, cmd_wdata, read_data_in;
    logic       cmd_ready, transfer, pwrite_out, rsp_valid, rsp_err, err_sticky, busy;
    logic [7:0] paddr_out, pwdata_out, rsp_rdata;

    apb_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .AW(8), .DW(8)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .transfer(transfer), .pwrite_out(pwrite_out), .paddr_out(paddr_out),
        .pwdata_out(pwdata_out), .xfer_done(xfer_done), .read_data_in(read_data_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .err_sticky(err_sticky), .err_clr(err_clr), .busy(busy)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state
    cmd_t       m_q[$];
    bit         m_xfer, m_resp, m_pushed;
    cmd_t       m_cur;
    int         m_xcyc;
    logic       m_rv, m_re, m_st;
    logic [7:0] m_rd;

    task automatic model_reset();
        m_q.delete();
        m_xfer = 0; m_resp = 0; m_pushed = 0;
        m_cur = '0; m_xcyc = 0;
        m_rv = 0; m_re = 0; m_st = 0; m_rd = 8'h00;
    endtask

    task automatic model_step();
        bit push;
        bit idle;
        push = cmd_valid && (m_q.size() < DEPTH);
        idle = !m_xfer && !m_resp;
        if (preset) begin
            model_reset();
        end else begin
            if (err_clr) m_st = 0;
            if (idle) begin
                if (m_q.size() > 0) begin
                    m_cur  = m_q.pop_front();
                    m_xfer = 1;
                    m_xcyc = 0;
                end
            end else if (m_xfer) begin
                m_xcyc++;
                if (xfer_done) begin
                    m_xfer = 0;
                    if (!m_cur.w) begin
                        m_rv = 1; m_rd = read_data_in; m_re = 0; m_resp = 1;
                    end
                end else if (m_xcyc == TIMEOUT) begin
                    m_xfer = 0;
                    m_st   = 1;
                    if (!m_cur.w) begin
                        m_rv = 1; m_rd = 8'hFF; m_re = 1; m_resp = 1;
                    end
                end
            end else if (rsp_ready) begin
                m_rv = 0;
                m_resp = 0;
            end
            if (push) m_q.push_back({cmd_write, cmd_addr, cmd_wdata});
            m_pushed = push;
        end
    endtask

    // Observation bookkeeping and responder controls
    bit         chk_en = 0;
    int         rmode = 0;
    int         rdelay = 1;
    bit         rr_rand = 0;
    bit         rd_fixed_en = 0;
    logic [7:0] rd_fixed = 8'h00;
    int         hi_cnt = 0;
    int         rv_cnt = 0;
    int         cyc = 0;
    logic       prev_tr = 1'b0;
    cmd_t       rise_cmd[$];
    int         rise_cyc[$];
    int         fall_cyc[$];

    task automatic cycle();
        @(posedge pclk);
        #1;
        cyc++;
        model_step();
        if (transfer) hi_cnt++;
        if (rsp_valid) rv_cnt++;
        if (transfer && !prev_tr) begin
            rise_cmd.push_back({pwrite_out, paddr_out, pwdata_out});
            rise_cyc.push_back(cyc);
        end
        if (!transfer && prev_tr) fall_cyc.push_back(cyc);
        prev_tr = transfer;
        case (rmode)
            0:       xfer_done = 1'b0;
            1:       xfer_done = m_xfer && (m_xcyc == rdelay - 1);
            default: xfer_done = m_xfer ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 9) == 0);
        endcase
        read_data_in = rd_fixed_en ? rd_fixed : 8'($urandom);
        if (rr_rand) rsp_ready = ($urandom_range(0, 2) == 0);
    endtask

    task automatic push_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (m_pushed) break;
        end
        if (!m_pushed) chk("push_accept_bound", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300 && busy; i++) cycle();
        chk(name, busy, 1'b0);
    endtask

    always @(negedge pclk) begin
        if (chk_en) begin
            chk("transfer", transfer, m_xfer);
            chk("pwrite_out", pwrite_out, m_cur.w);
            chk("paddr_out", paddr_out, m_cur.a);
            chk("pwdata_out", pwdata_out, m_cur.d);
            chk("cmd_ready", cmd_ready, m_q.size() < DEPTH);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_rdata", rsp_rdata, m_rd);
            chk("rsp_err", rsp_err, m_re);
            chk("err_sticky", err_sticky, m_st);
            chk("busy", busy, m_xfer || m_resp || (m_q.size() > 0));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        xfer_done = 1'b0; read_data_in = 8'h00; rsp_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        cycle();
        chk_en = 1;
        repeat (2) cycle();
        preset = 1'b0;

        // Reset then idle
        hi_cnt = 0;
        repeat (5) cycle();
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_rsp_valid", rsp_valid, 1'b0);
        chk("idle_no_transfer", hi_cnt, 0);

        // Single write, xfer_done two cycles after transfer rises
        rmode = 1; rdelay = 2;
        hi_cnt = 0; rv_cnt = 0; rise_cmd.delete();
        push_cmd(1'b1, 8'h05, 8'hAA);
        repeat (8) cycle();
        chk("wr_rise_count", rise_cmd.size(), 1);
        chk("wr_request", (rise_cmd.size() > 0) ? rise_cmd[0] : '0, 32'h105AA);
        chk("wr_transfer_cycles", hi_cnt, 2);
        chk("wr_no_rsp", rv_cnt, 0);

        // Write then read of the same address
        rise_cyc.delete(); fall_cyc.delete();
        rd_fixed_en = 1; rd_fixed = 8'hAA;
        push_cmd(1'b1, 8'h05, 8'hAA);
        push_cmd(1'b0, 8'h05, 8'h00);
        for (int i = 0; i < 40 && !rsp_valid; i++) cycle();
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_rdata", rsp_rdata, 8'hAA);
        chk("rd_rsp_err", rsp_err, 1'b0);
        chk("rd_gap", (rise_cyc.size() >= 2 && fall_cyc.size() >= 1) ? rise_cyc[1] - fall_cyc[0] : -1, 1);
        repeat (3) cycle();
        chk("rd_rsp_hold", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        cycle();
        chk("rd_rsp_cleared", rsp_valid, 1'b0);
        rsp_ready = 1'b0;
        rd_fixed_en = 0;
        wait_idle("rd_drained");

        // FIFO fill and pointer wrap with completions withheld
        rmode = 0; rise_cmd.delete();
        for (int i = 0; i < 5; i++) push_cmd(1'b1, 8'(i), 8'(8'h30 + i));
        chk("full_cmd_ready", cmd_ready, 1'b0);
        push_cmd(1'b1, 8'h05, 8'h35);
        rmode = 1; rdelay = 1;
        wait_idle("fifo_drained");
        chk("fifo_rise_count", rise_cmd.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("fifo_order", (rise_cmd.size() > i) ? rise_cmd[i].a : 8'hEE, 8'(i));
        chk("fifo_sticky_after_timeout", err_sticky, 1'b1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("fifo_sticky_cleared", err_sticky, 1'b0);

        // Read timeout
        rmode = 0; hi_cnt = 0;
        push_cmd(1'b0, 8'h10, 8'h00);
        for (int i = 0; i < 40 && !rsp_valid; i++) cycle();
        chk("to_transfer_cycles", hi_cnt, 16);
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 8'hFF);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_err_sticky", err_sticky, 1'b1);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("to_err_clr", err_sticky, 1'b0);

        // Reset while a transfer is in flight with two entries queued
        push_cmd(1'b1, 8'h20, 8'h01);
        push_cmd(1'b1, 8'h21, 8'h02);
        push_cmd(1'b1, 8'h22, 8'h03);
        chk("pre_rst_transfer", transfer, 1'b1);
        #2;
        preset = 1'b1;
        #1;
        model_reset();
        chk("rst_transfer_async", transfer, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        repeat (2) cycle();
        preset = 1'b0;
        hi_cnt = 0;
        repeat (20) cycle();
        chk("post_rst_no_transfer", hi_cnt, 0);
        chk("post_rst_busy", busy, 1'b0);

        // Randomized traffic
        rmode = 2; rr_rand = 1;
        for (int i = 0; i < 2000; i++) begin
            cycle();
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_write = $urandom_range(0, 1) == 1;
            cmd_addr  = 8'($urandom);
            cmd_wdata = 8'($urandom);
            err_clr   = ($urandom_range(0, 15) == 0);
        end
        cmd_valid = 1'b0; err_clr = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("random_drained");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
